// File: rtl/clock_mode_ctrl_if.sv
// Button, timer-status and counter-control bundle between the front panel / counter
// chains and clock_mode_ctrl.
//   btn_mode, btn_sel, btn_inc : raw active-high front-panel buttons (asynchronous)
//   timer_zero                 : all timer counters read zero
//   rezhim                     : display mode (00 clock, 01 set hours, 10 set minutes, 11 timer)
//   clk_en, inc_hr, inc_min, sec_clr        : wall-clock chain controls
//   tmr_en, inc_tmr, timer_reset, alarm     : countdown-timer chain controls
interface clock_mode_ctrl_if;
    logic       btn_mode;
    logic       btn_sel;
    logic       btn_inc;
    logic       timer_zero;
    logic [1:0] rezhim;
    logic       clk_en;
    logic       inc_hr;
    logic       inc_min;
    logic       sec_clr;
    logic       tmr_en;
    logic       inc_tmr;
    logic       timer_reset;
    logic       alarm;

    // Board / counter side: drives the buttons and timer status.
    modport master (
        output btn_mode, btn_sel, btn_inc, timer_zero,
        input  rezhim, clk_en, inc_hr, inc_min, sec_clr,
        input  tmr_en, inc_tmr, timer_reset, alarm
    );

    // Controller side.
    modport slave (
        input  btn_mode, btn_sel, btn_inc, timer_zero,
        output rezhim, clk_en, inc_hr, inc_min, sec_clr,
        output tmr_en, inc_tmr, timer_reset, alarm
    );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Mode and sequencing controller for the wall-clock and countdown-timer counter chains.
// Synchronises and locks out the three front-panel buttons, generates the 1 Hz tick and
// runs the mode FSM that drives the counter controls. All outputs are registered.
//   clock : system clock
//   reset : asynchronous active-low reset
//   bus   : clock_mode_ctrl_if.slave (buttons/timer_zero in, counter controls out)
module clock_mode_ctrl #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned LOCKOUT  = 1000000,
    parameter int unsigned ALARM_S  = 10
) (
    input logic              clock,
    input logic              reset,
    clock_mode_ctrl_if.slave bus
);

    localparam int unsigned DIV_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned LOCK_W = $clog2(LOCKOUT + 1);
    localparam int unsigned ALM_W  = (ALARM_S > 1) ? $clog2(ALARM_S) : 1;
    localparam int unsigned NBTN   = 3;
    localparam int unsigned B_MODE = 0;
    localparam int unsigned B_SEL  = 1;
    localparam int unsigned B_INC  = 2;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_HR   = 3'd1,
        SET_MIN  = 3'd2,
        TMR_IDLE = 3'd3,
        TMR_RUN  = 3'd4,
        TMR_DONE = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [DIV_W-1:0]  div_q, div_d;
    logic [NBTN-1:0]   sync1_q, sync1_d;
    logic [NBTN-1:0]   sync2_q, sync2_d;
    logic [NBTN-1:0]   prev_q, prev_d;
    logic [LOCK_W-1:0] lock_q [NBTN];
    logic [LOCK_W-1:0] lock_d [NBTN];
    logic [ALM_W-1:0]  alarm_cnt_q, alarm_cnt_d;

    logic [1:0] rezhim_q, rezhim_d;
    logic       clk_en_q, clk_en_d;
    logic       inc_hr_q, inc_hr_d;
    logic       inc_min_q, inc_min_d;
    logic       sec_clr_q, sec_clr_d;
    logic       tmr_en_q, tmr_en_d;
    logic       inc_tmr_q, inc_tmr_d;
    logic       timer_reset_q, timer_reset_d;
    logic       alarm_q, alarm_d;

    logic            tick_c;
    logic [NBTN-1:0] acc_c;
    logic            p_mode_c;
    logic            p_sel_c;
    logic            p_inc_c;

    function automatic logic [1:0] rezhim_of(input state_t s);
        case (s)
            RUN:     return 2'b00;
            SET_HR:  return 2'b01;
            SET_MIN: return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    // Free-running 1 Hz prescaler; independent of mode.
    always_comb begin
        tick_c = (div_q == DIV_W'(TICK_DIV - 1));
        div_d  = tick_c ? '0 : div_q + DIV_W'(1);
    end

    // Button front end: 2-flop sync, rising-edge detect, per-button lockout.
    always_comb begin
        sync1_d = {bus.btn_inc, bus.btn_sel, bus.btn_mode};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        acc_c   = '0;
        lock_d  = lock_q;
        for (int i = 0; i < int'(NBTN); i++) begin
            acc_c[i] = sync2_q[i] && !prev_q[i] && (lock_q[i] == '0);
            if (acc_c[i]) begin
                lock_d[i] = LOCK_W'(LOCKOUT);
            end else if (lock_q[i] != '0) begin
                lock_d[i] = lock_q[i] - LOCK_W'(1);
            end
        end
    end

    // Only the highest-priority accepted press acts; the others just consume their lockout.
    always_comb begin
        p_mode_c = acc_c[B_MODE];
        p_sel_c  = acc_c[B_SEL] && !acc_c[B_MODE];
        p_inc_c  = acc_c[B_INC] && !acc_c[B_SEL] && !acc_c[B_MODE];
    end

    // Mode FSM: next state and next values of all registered outputs.
    always_comb begin
        state_d       = state_q;
        alarm_cnt_d   = alarm_cnt_q;
        inc_hr_d      = 1'b0;
        inc_min_d     = 1'b0;
        sec_clr_d     = 1'b0;
        tmr_en_d      = 1'b0;
        inc_tmr_d     = 1'b0;
        timer_reset_d = 1'b0;

        case (state_q)
            RUN: begin
                if (p_mode_c) state_d = SET_HR;
            end
            SET_HR: begin
                if (p_mode_c)     state_d  = SET_MIN;
                else if (p_inc_c) inc_hr_d = 1'b1;
            end
            SET_MIN: begin
                if (p_mode_c || p_sel_c) begin
                    state_d   = TMR_IDLE;
                    sec_clr_d = 1'b1;
                end else if (p_inc_c) begin
                    inc_min_d = 1'b1;
                end
            end
            TMR_IDLE: begin
                if (p_mode_c) begin
                    state_d = RUN;
                end else if (p_sel_c) begin
                    if (!bus.timer_zero) state_d = TMR_RUN;
                end else if (p_inc_c) begin
                    inc_tmr_d = 1'b1;
                end
            end
            TMR_RUN: begin
                // Decrement only while non-zero so the timer never wraps.
                if (tick_c && !bus.timer_zero) tmr_en_d = 1'b1;
                if (p_mode_c) begin
                    state_d = RUN;
                end else if (p_sel_c) begin
                    state_d = TMR_IDLE;
                end else if (tick_c && bus.timer_zero) begin
                    state_d     = TMR_DONE;
                    alarm_cnt_d = '0;
                end
            end
            TMR_DONE: begin
                if (|acc_c) begin
                    state_d       = TMR_IDLE;
                    timer_reset_d = 1'b1;
                end else if (tick_c) begin
                    if (alarm_cnt_q == ALM_W'(ALARM_S - 1)) begin
                        state_d       = TMR_IDLE;
                        timer_reset_d = 1'b1;
                    end else begin
                        alarm_cnt_d = alarm_cnt_q + ALM_W'(1);
                    end
                end
            end
            default: state_d = RUN;
        endcase

        // Keyed on the next state so clk_en never appears alongside a setup rezhim.
        clk_en_d = tick_c && (state_d != SET_HR) && (state_d != SET_MIN);
        alarm_d  = (state_d == TMR_DONE);
        rezhim_d = rezhim_of(state_d);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            div_q         <= '0;
            sync1_q       <= '0;
            sync2_q       <= '0;
            prev_q        <= '0;
            for (int i = 0; i < int'(NBTN); i++) lock_q[i] <= '0;
            alarm_cnt_q   <= '0;
            rezhim_q      <= 2'b00;
            clk_en_q      <= 1'b0;
            inc_hr_q      <= 1'b0;
            inc_min_q     <= 1'b0;
            sec_clr_q     <= 1'b0;
            tmr_en_q      <= 1'b0;
            inc_tmr_q     <= 1'b0;
            timer_reset_q <= 1'b0;
            alarm_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            lock_q        <= lock_d;
            alarm_cnt_q   <= alarm_cnt_d;
            rezhim_q      <= rezhim_d;
            clk_en_q      <= clk_en_d;
            inc_hr_q      <= inc_hr_d;
            inc_min_q     <= inc_min_d;
            sec_clr_q     <= sec_clr_d;
            tmr_en_q      <= tmr_en_d;
            inc_tmr_q     <= inc_tmr_d;
            timer_reset_q <= timer_reset_d;
            alarm_q       <= alarm_d;
        end
    end

    assign bus.rezhim      = rezhim_q;
    assign bus.clk_en      = clk_en_q;
    assign bus.inc_hr      = inc_hr_q;
    assign bus.inc_min     = inc_min_q;
    assign bus.sec_clr     = sec_clr_q;
    assign bus.tmr_en      = tmr_en_q;
    assign bus.inc_tmr     = inc_tmr_q;
    assign bus.timer_reset = timer_reset_q;
    assign bus.alarm       = alarm_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed self-checking bench for clock_mode_ctrl (TICK_DIV=10, LOCKOUT=4, ALARM_S=3).
// n counts clock edges since the last reset release; ticks act on edges with n % 10 == 0.
module tb_clock_mode_ctrl;
    localparam int unsigned TICK_DIV = 10;
    localparam int unsigned LOCKOUT  = 4;
    localparam int unsigned ALARM_S  = 3;

    localparam logic [2:0] P_MODE = 3'b001;
    localparam logic [2:0] P_SEL  = 3'b010;
    localparam logic [2:0] P_INC  = 3'b100;

    logic clock = 1'b0;
    logic reset = 1'b0;

    clock_mode_ctrl_if bus ();

    clock_mode_ctrl #(
        .TICK_DIV(TICK_DIV),
        .LOCKOUT (LOCKOUT),
        .ALARM_S (ALARM_S)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int n     = 0;
    int c_clk, c_hr, c_min, c_sec, c_tmr_en, c_inc_tmr, c_trst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        c_clk = 0; c_hr = 0; c_min = 0; c_sec = 0;
        c_tmr_en = 0; c_inc_tmr = 0; c_trst = 0;
    endtask

    // Advance one or more clocks; sample 1 time unit after the edge and tally pulses.
    task automatic step(input int cycles = 1);
        repeat (cycles) begin
            @(posedge clock);
            #1;
            n++;
            c_clk     += (bus.clk_en === 1'b1) ? 1 : 0;
            c_hr      += (bus.inc_hr === 1'b1) ? 1 : 0;
            c_min     += (bus.inc_min === 1'b1) ? 1 : 0;
            c_sec     += (bus.sec_clr === 1'b1) ? 1 : 0;
            c_tmr_en  += (bus.tmr_en === 1'b1) ? 1 : 0;
            c_inc_tmr += (bus.inc_tmr === 1'b1) ? 1 : 0;
            c_trst    += (bus.timer_reset === 1'b1) ? 1 : 0;
        end
    endtask

    // Press: buttons rise after edge e, action is visible after edge e+3 (where it returns).
    task automatic press(input logic [2:0] mask);
        step(3);
        while ((n + 3) % int'(TICK_DIV) == 0) step();
        {bus.btn_inc, bus.btn_sel, bus.btn_mode} = mask;
        step(3);
        {bus.btn_inc, bus.btn_sel, bus.btn_mode} = 3'b000;
    endtask

    task automatic align();
        while (n % int'(TICK_DIV) != 1) step();
    endtask

    task automatic first_clk(input string tag);
        int k = 0;
        while (bus.clk_en !== 1'b1 && k < 20) begin step(); k++; end
        chk(tag, 32'(n), 32'd10);
    endtask

    task automatic wait_alarm(output int at);
        int k = 0;
        while (bus.alarm !== 1'b1 && k < 30) begin step(); k++; end
        at = n;
        chk("alarm_set", 32'(bus.alarm), 32'd1);
        chk("done_on_tick", 32'(at % int'(TICK_DIV)), 32'd0);
    endtask

    task automatic to_timer_run();
        bus.timer_zero = 1'b0;
        press(P_SEL);
        chk("tmr_run_rezhim", 32'(bus.rezhim), 32'd3);
    endtask

    initial begin
        int nd;
        int k;
        logic prev_alarm;
        bus.btn_mode = 1'b0; bus.btn_sel = 1'b0; bus.btn_inc = 1'b0;
        bus.timer_zero = 1'b0;
        clr();

        // Initial reset.
        step(3);
        chk("rst_rezhim", 32'(bus.rezhim), 32'd0);
        chk("rst_outs", 32'({bus.clk_en, bus.inc_hr, bus.inc_min, bus.sec_clr, bus.tmr_en,
                             bus.inc_tmr, bus.timer_reset, bus.alarm}), 32'd0);
        reset = 1'b1;
        n = 0;
        first_clk("first_clk_en");
        step();
        chk("clk_en_width", 32'(bus.clk_en), 32'd0);

        // Mode walk into SET_HR; setup increments.
        press(P_MODE);
        chk("walk_01", 32'(bus.rezhim), 32'd1);
        clr();
        for (int i = 0; i < 3; i++) begin
            press(P_INC);
            chk("inc_hr_latency", 32'(bus.inc_hr), 32'd1);
            step();
            chk("inc_hr_width", 32'(bus.inc_hr), 32'd0);
        end
        chk("inc_hr_count", 32'(c_hr), 32'd3);

        // Bounce within the lockout yields a single pulse.
        step(3);
        bus.btn_inc = 1'b1; step();
        bus.btn_inc = 1'b0; step();
        bus.btn_inc = 1'b1; step(2);
        bus.btn_inc = 1'b0; step(8);
        chk("bounce_one_pulse", 32'(c_hr), 32'd4);

        press(P_MODE);
        chk("walk_10", 32'(bus.rezhim), 32'd2);
        press(P_INC);
        chk("inc_min_pulse", 32'(bus.inc_min), 32'd1);
        step(12);
        chk("no_clk_en_in_setup", 32'(c_clk), 32'd0);
        chk("no_inc_min_in_hr", 32'(c_min), 32'd1);

        clr();
        press(P_MODE);
        chk("walk_11", 32'(bus.rezhim), 32'd3);
        chk("sec_clr_pulse", 32'(bus.sec_clr), 32'd1);
        step();
        chk("sec_clr_count", 32'(c_sec), 32'd1);

        // Timer setup in TMR_IDLE.
        clr();
        press(P_INC);
        press(P_INC);
        step();
        chk("inc_tmr_count", 32'(c_inc_tmr), 32'd2);

        // Zero start: sel with timer_zero=1 does nothing; clock keeps running.
        bus.timer_zero = 1'b1;
        press(P_SEL);
        align();
        clr();
        step(30);
        chk("zero_start_no_tmr_en", 32'(c_tmr_en), 32'd0);
        chk("clk_runs_idle", 32'(c_clk), 32'd3);
        chk("zero_start_rezhim", 32'(bus.rezhim), 32'd3);

        press(P_MODE);
        chk("walk_00", 32'(bus.rezhim), 32'd0);

        // Back to TMR_IDLE, start timer, check tmr_en per tick.
        press(P_MODE); press(P_MODE); press(P_MODE);
        chk("back_idle", 32'(bus.rezhim), 32'd3);
        to_timer_run();
        align();
        clr();
        step(20);
        chk("tmr_en_per_tick", 32'(c_tmr_en), 32'd2);
        while (n % int'(TICK_DIV) != 0) step();
        chk("tmr_en_on_tick", 32'(bus.tmr_en), 32'd1);
        step();
        chk("tmr_en_width", 32'(bus.tmr_en), 32'd0);

        // Priority: mode+sel together -> RUN; a following sel does nothing.
        press(P_MODE | P_SEL);
        chk("prio_rezhim", 32'(bus.rezhim), 32'd0);
        step();
        bus.btn_sel = 1'b1; step(2);
        bus.btn_sel = 1'b0; step(6);
        chk("prio_sel_dropped", 32'(bus.rezhim), 32'd0);

        // Timer expiry and alarm timeout.
        press(P_MODE); press(P_MODE); press(P_MODE);
        to_timer_run();
        clr();
        bus.timer_zero = 1'b1;
        wait_alarm(nd);
        chk("no_tmr_en_at_zero", 32'(c_tmr_en), 32'd0);
        k = 0;
        prev_alarm = bus.alarm;
        while (bus.timer_reset !== 1'b1 && k < 40) begin
            prev_alarm = bus.alarm;
            step();
            k++;
        end
        chk("alarm_timeout_ticks", 32'(n - nd), 32'd30);
        chk("alarm_high_before_exit", 32'(prev_alarm), 32'd1);
        chk("alarm_drop_on_exit", 32'(bus.alarm), 32'd0);
        step();
        chk("timer_reset_width", 32'(bus.timer_reset), 32'd0);

        // Any press exits TMR_DONE with timer_reset.
        to_timer_run();
        bus.timer_zero = 1'b1;
        wait_alarm(nd);
        press(P_INC);
        chk("done_press_trst", 32'(bus.timer_reset), 32'd1);
        chk("done_press_alarm", 32'(bus.alarm), 32'd0);
        chk("done_press_rezhim", 32'(bus.rezhim), 32'd3);

        // Reset asserted mid-run in TMR_DONE.
        to_timer_run();
        bus.timer_zero = 1'b1;
        wait_alarm(nd);
        step(2);
        reset = 1'b0;
        #1;
        chk("mid_rst_rezhim", 32'(bus.rezhim), 32'd0);
        chk("mid_rst_outs", 32'({bus.clk_en, bus.inc_hr, bus.inc_min, bus.sec_clr, bus.tmr_en,
                                 bus.inc_tmr, bus.timer_reset, bus.alarm}), 32'd0);
        bus.timer_zero = 1'b0;
        step(3);
        reset = 1'b1;
        n = 0;
        first_clk("first_clk_en_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
